// File: rtl/task_fifo_pkg.sv
// rtl/task_fifo_pkg.sv - shared task-type codes and entry/lane helpers for the task FIFO bank
package task_fifo_pkg;

  localparam logic TASK_PUSH = 1'b1;
  localparam logic TASK_POP  = 1'b0;

  // Wide enough for any realistic {type, treeId, data}; callers slice to their entry width.
  localparam int ENTRY_MAX = 128;

  function automatic int lane_of(input int tree_id, input int level);
    return tree_id % level;
  endfunction

  function automatic logic [ENTRY_MAX-1:0] make_entry(
    input logic                 task_type,
    input int                   tree_id,
    input int                   tree_bits,
    input logic [ENTRY_MAX-1:0] data,
    input int                   data_w
  );
    logic [ENTRY_MAX-1:0] e;
    e = data;
    e = e | (ENTRY_MAX'(tree_id) << data_w);
    e = e | (ENTRY_MAX'(task_type) << (data_w + tree_bits));
    return e;
  endfunction

endpackage

// File: rtl/task_fifo_bank_if.sv
// rtl/task_fifo_bank_if.sv - write/read channel between the bank arbiter and one lane FIFO
interface task_fifo_bank_if #(
  parameter int EW = 35,
  parameter int CW = 4
);
  logic          wr_en;
  logic [EW-1:0] wr_data;
  logic          pop;
  logic [EW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;

  modport master (output wr_en, wr_data, pop, input rd_data, empty, full, count);
  modport slave  (input wr_en, wr_data, pop, output rd_data, empty, full, count);
endinterface

// File: rtl/task_lane_fifo.sv
// rtl/task_lane_fifo.sv - single-lane task FIFO with registered read data and occupancy count
module task_lane_fifo #(
  parameter int EW    = 35,
  parameter int DEPTH = 8
) (
  input logic              i_clk,
  input logic              i_arst_n,
  task_fifo_bank_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] rd_data_q, rd_data_d;
  logic          wr_acc;
  logic          pop_eff;

  always_comb begin
    wr_acc    = bus.wr_en && (count_q != CW'(DEPTH));
    pop_eff   = bus.pop && (count_q != '0);
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (pop_eff) begin
      rptr_d    = rptr_q + 1'b1;
      rd_data_d = mem_q[rptr_q];
    end
    if (wr_acc && !pop_eff)      count_d = count_q + 1'b1;
    else if (!wr_acc && pop_eff) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is left unreset: a zero count already makes stale entries unreachable.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.wr_data;
  end

  assign bus.rd_data = rd_data_q;
  assign bus.count   = count_q;
  assign bus.empty   = (count_q == '0);
  assign bus.full    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/task_fifo_bank.sv
// rtl/task_fifo_bank.sv - per-lane task FIFO bank with round-robin tree arbitration
// Optional occupancy/stall statistics under TASK_FIFO_STATS_EN.
module task_fifo_bank
  import task_fifo_pkg::*;
#(
  parameter int PTW           = 16,
  parameter int MTW           = 16,
  parameter int LEVEL         = 4,
  parameter int LEVEL_BITS    = $clog2(LEVEL),
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int DEPTH         = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_arst_n,
  input  logic [TREE_NUM-1:0]                           i_req_valid,
  input  logic [TREE_NUM-1:0]                           i_req_push,
  input  logic [TREE_NUM-1:0][PTW+MTW-1:0]              i_req_data,
  output logic [TREE_NUM-1:0]                           o_req_ready,
  input  logic [LEVEL-1:0]                              i_pop_TaskFIFO,
  output logic [LEVEL-1:0][PTW+MTW+TREE_NUM_BITS:0]     o_TaskFIFO_data,
  output logic [LEVEL-1:0]                              o_TaskFIFO_empty,
  output logic [LEVEL-1:0][$clog2(DEPTH):0]             o_lane_count
`ifdef TASK_FIFO_STATS_EN
  ,
  input  logic                                          i_stats_clr,
  output logic [LEVEL-1:0][$clog2(DEPTH):0]             o_hwm,
  output logic [LEVEL-1:0][31:0]                        o_stall_cnt
`endif
);

  localparam int DW  = PTW + MTW;
  localparam int EW  = DW + TREE_NUM_BITS + 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CPL = TREE_NUM / LEVEL;
  localparam int RRW = (CPL > 1) ? $clog2(CPL) : 1;

  logic [LEVEL-1:0]               lane_full;
  logic [LEVEL-1:0]               lane_wr;
  logic [LEVEL-1:0][EW-1:0]       lane_wdata;
  logic [LEVEL-1:0][CW-1:0]       lane_count;
  logic [LEVEL-1:0][RRW-1:0]      rr_q, rr_d;
  logic [LEVEL-1:0][RRW-1:0]      gnt_k;
  logic [LEVEL-1:0]               gnt_found;
  logic [TREE_NUM_BITS-1:0]       cand_t;
  logic [TREE_NUM_BITS-1:0]       gnt_t;
  logic [ENTRY_MAX-1:0]           entry;

  // Candidate k of lane l is tree {k, l}; search starts at the lane's rr pointer.
  always_comb begin
    gnt_found   = '0;
    gnt_k       = '0;
    o_req_ready = '0;
    lane_wr     = '0;
    lane_wdata  = '0;
    rr_d        = rr_q;
    cand_t      = '0;
    gnt_t       = '0;
    entry       = '0;
    for (int l = 0; l < LEVEL; l++) begin
      for (int off = 0; off < CPL; off++) begin
        cand_t = TREE_NUM_BITS'((((int'(rr_q[l]) + off) % CPL) << LEVEL_BITS) | l);
        if (!gnt_found[l] && i_req_valid[cand_t]) begin
          gnt_found[l] = 1'b1;
          gnt_k[l]     = RRW'((int'(rr_q[l]) + off) % CPL);
        end
      end
      gnt_t = TREE_NUM_BITS'((int'(gnt_k[l]) << LEVEL_BITS) | l);
      // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
      if (gnt_found[l] && !lane_full[l]) begin
        o_req_ready[gnt_t] = 1'b1;
        lane_wr[l]         = 1'b1;
        entry = make_entry(i_req_push[gnt_t] ? TASK_PUSH : TASK_POP, int'(gnt_t), TREE_NUM_BITS,
                           i_req_push[gnt_t] ? ENTRY_MAX'(i_req_data[gnt_t]) : '0, DW);
        lane_wdata[l] = entry[EW-1:0];
        rr_d[l]       = RRW'((int'(gnt_k[l]) + 1) % CPL);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) rr_q <= '0;
    else           rr_q <= rr_d;
  end

  for (genvar l = 0; l < LEVEL; l++) begin : g_lane
    task_fifo_bank_if #(.EW(EW), .CW(CW)) lane_bus ();

    assign lane_bus.wr_en   = lane_wr[l];
    assign lane_bus.wr_data = lane_wdata[l];
    assign lane_bus.pop     = i_pop_TaskFIFO[l];

    task_lane_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .bus      (lane_bus.slave)
    );

    assign lane_full[l]        = lane_bus.full;
    assign lane_count[l]       = lane_bus.count;
    assign o_TaskFIFO_data[l]  = lane_bus.rd_data;
    assign o_TaskFIFO_empty[l] = lane_bus.empty;
  end

  assign o_lane_count = lane_count;

`ifdef TASK_FIFO_STATS_EN
  logic [LEVEL-1:0]          lane_stall;
  logic [LEVEL-1:0][CW-1:0]  hwm_q;
  logic [LEVEL-1:0][31:0]    stall_q;

  always_comb begin
    lane_stall = '0;
    for (int l = 0; l < LEVEL; l++) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        if (lane_of(t, LEVEL) == l && i_req_valid[t] && !o_req_ready[t]) lane_stall[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else if (i_stats_clr) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      for (int l = 0; l < LEVEL; l++) begin
        if (lane_count[l] > hwm_q[l])          hwm_q[l]   <= lane_count[l];
        if (lane_stall[l] && (stall_q[l] != '1)) stall_q[l] <= stall_q[l] + 32'd1;
      end
    end
  end

  assign o_hwm       = hwm_q;
  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_task_fifo_bank.sv
// tb/tb_task_fifo_bank.sv - directed scoreboard bench for task_fifo_bank (4-tree and 8-tree builds)
module tb_task_fifo_bank;

  localparam int LEVEL = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic [3:0]        a_valid, a_push, a_ready, a_pop, a_empty;
  logic [3:0][31:0]  a_data;
  logic [3:0][34:0]  a_rdata;
  logic [3:0][3:0]   a_cnt;

  logic [7:0]        b_valid, b_push, b_ready;
  logic [7:0][31:0]  b_data;
  logic [3:0]        b_pop, b_empty;
  logic [3:0][35:0]  b_rdata;
  logic [3:0][3:0]   b_cnt;

  task_fifo_bank #(.PTW(16), .MTW(16), .LEVEL(LEVEL), .TREE_NUM(4), .DEPTH(DEPTH)) u_dut_a (
    .i_clk            (clk),
    .i_arst_n         (arst_n),
    .i_req_valid      (a_valid),
    .i_req_push       (a_push),
    .i_req_data       (a_data),
    .o_req_ready      (a_ready),
    .i_pop_TaskFIFO   (a_pop),
    .o_TaskFIFO_data  (a_rdata),
    .o_TaskFIFO_empty (a_empty),
    .o_lane_count     (a_cnt)
  );

  task_fifo_bank #(.PTW(16), .MTW(16), .LEVEL(LEVEL), .TREE_NUM(8), .DEPTH(DEPTH)) u_dut_b (
    .i_clk            (clk),
    .i_arst_n         (arst_n),
    .i_req_valid      (b_valid),
    .i_req_push       (b_push),
    .i_req_data       (b_data),
    .o_req_ready      (b_ready),
    .i_pop_TaskFIFO   (b_pop),
    .o_TaskFIFO_data  (b_rdata),
    .o_TaskFIFO_empty (b_empty),
    .o_lane_count     (b_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [34:0] exp_q [4][$];
  logic [34:0] last_a [4];
  logic [35:0] exp_b [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int t, input bit is_push, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    a_valid[t] = 1'b1;
    a_push[t]  = is_push;
    a_data[t]  = d;
    for (int n = 0; n < 16 && !ok; n++) begin
      #1;
      if (a_ready[t]) begin
        ok = 1'b1;
        exp_q[t % 4].push_back({is_push, 2'(t), is_push ? d : 32'h0});
      end
      @(posedge clk);
      #1;
    end
    a_valid[t] = 1'b0;
    chk($sformatf("send_accept_t%0d", t), 64'(ok), 64'd1);
  endtask

  task automatic pop_a(input int l, input string tag);
    logic [34:0] e;
    chk($sformatf("%s_empty_flag", tag), 64'(a_empty[l]), 64'(exp_q[l].size() == 0));
    if (exp_q[l].size() != 0) begin
      e = exp_q[l].pop_front();
      last_a[l] = e;
    end else begin
      e = last_a[l];
    end
    a_pop[l] = 1'b1;
    tick();
    a_pop[l] = 1'b0;
    chk(tag, 64'(a_rdata[l]), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, g4;
    arst_n  = 1'b0;
    a_valid = '0; a_push = '0; a_data = '0; a_pop = '0;
    b_valid = '0; b_push = '0; b_data = '0; b_pop = '0;
    for (int l = 0; l < 4; l++) last_a[l] = '0;
    #12;

    chk("rst_empty", 64'(a_empty), 64'hF);
    chk("rst_count", 64'(a_cnt), 64'h0);
    for (int l = 0; l < 4; l++) chk($sformatf("rst_data_l%0d", l), 64'(a_rdata[l]), 64'h0);
    a_valid = 4'hF; a_push = 4'hF;
    b_valid = 8'hFF; b_push = 8'hFF;
    #1;
    chk("rst_ready_a", 64'(a_ready), 64'hF);
    chk("rst_ready_b", 64'(b_ready), 64'h0F);
    a_valid = '0; b_valid = '0;
    @(negedge clk);
    arst_n = 1'b1;
    tick();

    // Tree 2 push; empty falls only after the accepting edge.
    a_valid[2] = 1'b1; a_push[2] = 1'b1; a_data[2] = 32'h0001_00AA;
    #1;
    chk("tp1_ready", 64'(a_ready[2]), 64'd1);
    chk("tp1_empty_before", 64'(a_empty[2]), 64'd1);
    exp_q[2].push_back({1'b1, 2'd2, 32'h0001_00AA});
    @(posedge clk);
    #1;
    a_valid[2] = 1'b0;
    chk("tp1_empty_after", 64'(a_empty[2]), 64'd0);
    chk("tp1_count", 64'(a_cnt[2]), 64'd1);
    tick();
    pop_a(2, "tp1_pop");
    chk("tp1_const", 64'(a_rdata[2]), 64'h6_0001_00AA);

    // Pop request: data field forced to zero.
    send_a(1, 1'b0, 32'hFFFF_FFFF);
    tick();
    pop_a(1, "popreq_pop");
    chk("popreq_const", 64'(a_rdata[1]), 64'h1_0000_0000);

    // Fill lane 3, then pop+push in one cycle against a full lane.
    for (int i = 0; i < 8; i++) send_a(3, 1'b1, 32'hC000_0000 + i);
    chk("full_count", 64'(a_cnt[3]), 64'd8);
    a_valid[3] = 1'b1; a_push[3] = 1'b1; a_data[3] = 32'hC000_0008;
    a_pop[3] = 1'b1;
    #1;
    chk("full_no_ready", 64'(a_ready[3]), 64'd0);
    @(posedge clk);
    #1;
    a_pop[3] = 1'b0;
    last_a[3] = exp_q[3].pop_front();
    chk("full_pop_data", 64'(a_rdata[3]), 64'(last_a[3]));
    chk("full_pop_count", 64'(a_cnt[3]), 64'd7);
    chk("full_next_ready", 64'(a_ready[3]), 64'd1);
    exp_q[3].push_back({1'b1, 2'd3, 32'hC000_0008});
    @(posedge clk);
    #1;
    a_valid[3] = 1'b0;
    chk("full_refill_count", 64'(a_cnt[3]), 64'd8);
    for (int i = 0; i < 8; i++) pop_a(3, $sformatf("drain3_%0d", i));
    chk("drain3_empty", 64'(a_empty[3]), 64'd1);

    // Pop on empty lane 0 together with a push to it.
    a_pop[0] = 1'b1;
    a_valid[0] = 1'b1; a_push[0] = 1'b1; a_data[0] = 32'h5A5A_0000;
    #1;
    chk("pe_ready", 64'(a_ready[0]), 64'd1);
    exp_q[0].push_back({1'b1, 2'd0, 32'h5A5A_0000});
    @(posedge clk);
    #1;
    a_pop[0] = 1'b0; a_valid[0] = 1'b0;
    chk("pe_data_hold", 64'(a_rdata[0]), 64'(last_a[0]));
    chk("pe_count", 64'(a_cnt[0]), 64'd1);
    pop_a(0, "pe_pop");

    // Reset mid-operation with lane 1 holding 5 entries.
    for (int i = 0; i < 5; i++) send_a(1, 1'b1, 32'h1111_0000 + i);
    chk("mr_count_before", 64'(a_cnt[1]), 64'd5);
    #2;
    arst_n = 1'b0;
    #1;
    chk("mr_count", 64'(a_cnt), 64'h0);
    chk("mr_empty", 64'(a_empty), 64'hF);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("mr_data_l%0d", l), 64'(a_rdata[l]), 64'h0);
      exp_q[l].delete();
      last_a[l] = '0;
    end
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    send_a(1, 1'b1, 32'hBEEF_0001);
    tick();
    pop_a(1, "mr_readback");

    // 8-tree build: trees 0 and 4 share lane 0 and must alternate.
    g0 = 0; g4 = 0;
    b_valid[0] = 1'b1; b_push[0] = 1'b1;
    b_valid[4] = 1'b1; b_push[4] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_data[0] = 32'hA000_0000 + i;
      b_data[4] = 32'hB000_0000 + i;
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 64'(b_ready[0]), 64'(i % 2 == 0));
      chk($sformatf("rr_gnt4_%0d", i), 64'(b_ready[4]), 64'(i % 2 == 1));
      if (b_ready[0]) begin
        g0++;
        exp_b.push_back({1'b1, 3'd0, 32'hA000_0000 + i});
      end
      if (b_ready[4]) begin
        g4++;
        exp_b.push_back({1'b1, 3'd4, 32'hB000_0000 + i});
      end
      @(posedge clk);
      #1;
    end
    b_valid = '0;
    chk("rr_total0", 64'(g0), 64'd4);
    chk("rr_total4", 64'(g4), 64'd4);
    chk("rr_count", 64'(b_cnt[0]), 64'd8);
    for (int i = 0; i < 8; i++) begin
      logic [35:0] e;
      e = (exp_b.size() != 0) ? exp_b.pop_front() : 36'h0;
      b_pop[0] = 1'b1;
      tick();
      b_pop[0] = 1'b0;
      chk($sformatf("rr_drain_%0d", i), 64'(b_rdata[0]), 64'(e));
    end
    chk("rr_drain_empty", 64'(b_empty[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/task_fifo_bank.md
Name: task_fifo_bank

Overview:
- Upstream stage feeding the per-lane task distributor of the vPIFO scheduler.
- Accepts push/pop requests from TREE_NUM virtual-PIFO client ports.
- Maps each tree to an RPU lane (lane = treeId mod LEVEL), round-robin arbitrates trees sharing a lane, and buffers tasks in one FIFO per lane.
- Exposes a pop/data/empty interface with 1-cycle read latency, which is what the distributor consumes.

Parameters:
- PTW, 16, payload width
- MTW, 16, metadata width
- LEVEL, 4, RPU/lane count (power of 2)
- LEVEL_BITS, $clog2(LEVEL), lane index width
- TREE_NUM, 4, virtual tree count (power of 2, >= LEVEL)
- TREE_NUM_BITS, $clog2(TREE_NUM), treeId width
- DEPTH, 8, entries per lane FIFO (power of 2, >= 2)

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  async active-low reset
- i_req_valid  in  [TREE_NUM-1:0]  task request per tree
- i_req_push  in  [TREE_NUM-1:0]  1 = push, 0 = pop
- i_req_data  in  [PTW+MTW-1:0] x TREE_NUM  push data; ignored for pop
- o_req_ready  out  [TREE_NUM-1:0]  request accepted this cycle when valid&ready
- i_pop_TaskFIFO  in  [LEVEL-1:0]  lane pop strobe
- o_TaskFIFO_data  out  [PTW+MTW+TREE_NUM_BITS:0] x LEVEL  {type, treeId, data}
- o_TaskFIFO_empty  out  [LEVEL-1:0]  lane empty
- o_lane_count  out  [$clog2(DEPTH):0] x LEVEL  lane occupancy

Behaviour:
- Reset is i_arst_n, asynchronous, active-low; clock is i_clk. Reset values:
  - all counts and read/write pointers 0
  - o_TaskFIFO_empty all 1s
  - o_TaskFIFO_data all 0
  - round-robin pointers 0
  - o_req_ready follows the combinational rule below (all trees may be granted after reset)
- Entry format: bit MSB = type (1 push, 0 pop), then treeId, then data.
  - For pop requests, data is stored as '0 regardless of i_req_data.
- Lane l candidates: trees t with t[LEVEL_BITS-1:0] == l.
- Per lane per cycle, at most one write. Grant goes to the first valid candidate at or after the lane rr pointer.
- o_req_ready[t] = 1 only when the lane is not full (count < DEPTH, registered) and t is that lane's grant.
  - Ready is combinational from i_req_valid; valid must not depend on ready.
- The rr pointer advances to the granted tree + 1 (within the lane's candidate set) only on an accepted write; otherwise it holds.
- Full lane: no grant, even if i_pop_TaskFIFO is asserted in the same cycle (ready depends on registered count only).
- Read:
  - i_pop_TaskFIFO[l] with empty=0: the head entry is registered into o_TaskFIFO_data[l] and is visible the cycle after the pop. It holds until the next effective pop.
  - Pop while empty: ignored; data and count unchanged.
- o_TaskFIFO_empty[l] = (count == 0), registered, so a write becomes visible as non-empty the cycle after acceptance (no write-to-read bypass).
- Simultaneous accepted write and effective pop on a lane: count unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Order: FIFO order per lane; per-tree order is preserved because a tree always maps to the same lane.
- Reset mid-operation: all contents are discarded immediately; outputs return to reset values.

Optional Feature:
- Macro TASK_FIFO_STATS_EN.
- When defined, adds per-lane outputs:
  - o_hwm ([$clog2(DEPTH):0] x LEVEL): occupancy high-water mark, updated each cycle as max(hwm, count)
  - o_stall_cnt (32 b x LEVEL): counts cycles where some candidate is valid but not ready; saturates at all-ones
  - i_stats_clr (1 b): synchronous clear of both, which takes priority over updates
- Both counters reset to 0.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package task_fifo_pkg holds:
  - TASK_PUSH = 1'b1 and TASK_POP = 1'b0
  - a function building the entry {type, treeId, data}
  - the lane-of-tree function (treeId mod LEVEL)
- One sub-module, task_lane_fifo: single lane, registered read, count/empty/full. It is instantiated LEVEL times from a generate loop.
- The arbiter stays in the top module.

Test Plan (PTW=MTW=16, LEVEL=4, TREE_NUM=4, DEPTH=8):
- Reset, then tree 2 pushes 0x0001_00AA; pop lane 2 two cycles later. Expect empty[2] to fall 1 cycle after acceptance and data[2] = {1, 2'd2, 0x000100AA} the cycle after the pop.
- Tree 1 issues a pop request with i_req_data = 0xFFFF_FFFF. Expect entry {0, 2'd1, 32'h0} in lane 1.
- With TREE_NUM=8, trees 0 and 4 are valid every cycle. Expect lane 0 grants to alternate 0, 4, 0, 4 and both trees to receive equal counts over 8 cycles.
- Fill lane 3 with 8 pushes. Expect ready[3] = 0 and count = 8; a pop and push in the same cycle is not accepted; the next cycle push is accepted and count returns to 8.
- Pop lane 0 while empty, simultaneous with a push to lane 0. Expect data unchanged, count = 1 the next cycle, and the subsequent pop to return the pushed entry.
- Assert reset with lane 1 holding 5 entries. Expect count 0, empty = 1 and data = 0 immediately; a push after release is read back correctly.
